// File: rtl/mnist_lut_simple_classifier.sv
// rtl/mnist_lut_simple_classifier.sv - three-layer 6-input LUT network classifier, one image per clock.
// Input m of LUT k reads previous-layer bit (k*6+m) mod N_prev; every layer output is registered.
module mnist_lut_simple_classifier #(
  parameter int USER_WIDTH = 2,
  // 64'hFFFE_FEE8_FEE8_E880 is the 6-input majority table (1 iff >= 3 address bits set)
  parameter logic [256*64-1:0] INIT0 = {256{64'hFFFE_FEE8_FEE8_E880}},
  parameter logic [64*64-1:0]  INIT1 = {64{64'hFFFE_FEE8_FEE8_E880}},
  parameter logic [10*64-1:0]  INIT2 = {10{64'hFFFE_FEE8_FEE8_E880}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cke,
  input  logic [USER_WIDTH-1:0] in_user,
  input  logic [783:0]          in_data,
  input  logic                  in_valid,
  output logic [USER_WIDTH-1:0] out_user,
  output logic [9:0]            out_data,
  output logic                  out_valid
);
  localparam int NIN = 784;
  localparam int N0  = 256;
  localparam int N1  = 64;
  localparam int N2  = 10;
  localparam int L2_TOP = N2 * 6;

  logic [N0-1:0] l0_d, l0_q;
  logic [N1-1:0] l1_d, l1_q;
  logic [N2-1:0] l2_d, l2_q;
  logic [2:0]                  valid_q;
  logic [2:0][USER_WIDTH-1:0]  user_q;

  for (genvar k = 0; k < N0; k++) begin : g_l0
    localparam logic [63:0] TABLE = INIT0[k*64 +: 64];
    logic [5:0] addr;
    for (genvar m = 0; m < 6; m++) begin : g_in
      assign addr[m] = in_data[(k*6+m) % NIN];
    end
    assign l0_d[k] = TABLE[addr];
  end

  for (genvar k = 0; k < N1; k++) begin : g_l1
    localparam logic [63:0] TABLE = INIT1[k*64 +: 64];
    logic [5:0] addr;
    for (genvar m = 0; m < 6; m++) begin : g_in
      assign addr[m] = l0_q[(k*6+m) % N0];
    end
    assign l1_d[k] = TABLE[addr];
  end

  for (genvar k = 0; k < N2; k++) begin : g_l2
    localparam logic [63:0] TABLE = INIT2[k*64 +: 64];
    logic [5:0] addr;
    for (genvar m = 0; m < 6; m++) begin : g_in
      assign addr[m] = l1_q[(k*6+m) % N1];
    end
    assign l2_d[k] = TABLE[addr];
  end

  // Layer 2 only reaches layer-1 bits below L2_TOP; the rest are genuinely unconnected.
  logic unused_l1_tail;
  assign unused_l1_tail = ^l1_q[N1-1:L2_TOP];

  always_ff @(posedge clk) begin
    if (reset) begin
      l0_q    <= '0;
      l1_q    <= '0;
      l2_q    <= '0;
      valid_q <= '0;
      user_q  <= '0;
    end else if (cke) begin
      l0_q    <= l0_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
      valid_q <= {valid_q[1:0], in_valid};
      user_q  <= {user_q[1:0], in_user};
    end
  end

  assign out_data  = l2_q;
  assign out_valid = valid_q[2];
  assign out_user  = user_q[2];

endmodule

// File: tb/tb_mnist_lut_simple_classifier.sv
// tb/tb_mnist_lut_simple_classifier.sv - bench for the LUT classifier, majority and bit-0 table instances.
module tb_mnist_lut_simple_classifier;
  localparam logic [63:0] BIT0_TBL = 64'hAAAA_AAAA_AAAA_AAAA;

  logic         clk = 1'b0;
  logic         reset;
  logic         cke;
  logic         in_valid;
  logic [783:0] in_data;
  logic [8:0]   in_user;
  logic [8:0]   m_user;
  logic [9:0]   m_data;
  logic         m_valid;
  logic [1:0]   a_user;
  logic [9:0]   a_data;
  logic         a_valid;

  mnist_lut_simple_classifier #(.USER_WIDTH(9)) dut (
    .clk(clk), .reset(reset), .cke(cke),
    .in_user(in_user), .in_data(in_data), .in_valid(in_valid),
    .out_user(m_user), .out_data(m_data), .out_valid(m_valid)
  );

  mnist_lut_simple_classifier #(
    .USER_WIDTH(2),
    .INIT0({256{BIT0_TBL}}),
    .INIT1({64{BIT0_TBL}}),
    .INIT2({10{BIT0_TBL}})
  ) dut_a (
    .clk(clk), .reset(reset), .cke(cke),
    .in_user(in_user[1:0]), .in_data(in_data), .in_valid(in_valid),
    .out_user(a_user), .out_data(a_data), .out_valid(a_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         acc;
    logic [8:0] user;
    logic [9:0] dm;
    logic [9:0] da;
  } exp_t;

  typedef struct {
    logic [783:0] img;
    logic [8:0]   user;
    logic [9:0]   exp_maj;
    logic [9:0]   exp_bit0;
    string        name;
  } vec_t;

  exp_t sbq[$];
  int   ecnt = 0;
  bit   mon_en = 1'b0;
  int   n_tot = 0;
  int   n_pass = 0;
  int   out_cnt = 0;
  int   last_seen = 0;
  int   last_pos = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Network evaluated from the rules: majority = at least 3 of 6 inputs high, bit0 = input 0.
  function automatic logic [9:0] ref_model(input logic [783:0] img, input bit maj);
    bit l0[256];
    bit l1[64];
    logic [9:0] r;
    for (int k = 0; k < 256; k++) begin
      int ones = 0;
      for (int m = 0; m < 6; m++) if (img[(k*6+m) % 784]) ones++;
      l0[k] = maj ? (ones >= 3) : img[(k*6) % 784];
    end
    for (int k = 0; k < 64; k++) begin
      int ones = 0;
      for (int m = 0; m < 6; m++) if (l0[(k*6+m) % 256]) ones++;
      l1[k] = maj ? (ones >= 3) : l0[(k*6) % 256];
    end
    for (int k = 0; k < 10; k++) begin
      int ones = 0;
      for (int m = 0; m < 6; m++) if (l1[(k*6+m) % 64]) ones++;
      r[k] = maj ? (ones >= 3) : l1[(k*6) % 64];
    end
    return r;
  endfunction

  function automatic logic [783:0] rand_img();
    logic [783:0] img;
    int dens = int'($urandom_range(10, 90));
    for (int p = 0; p < 784; p++) img[p] = (int'($urandom_range(0, 99)) < dens);
    return img;
  endfunction

  // Acceptance tracking: entries are tagged with the index of the enabled edge that took them.
  initial forever begin
    @(posedge clk);
    if (reset) sbq.delete();
    else if (cke) begin
      ecnt++;
      if (in_valid) begin
        exp_t e;
        e.acc  = ecnt;
        e.user = in_user;
        e.dm   = ref_model(in_data, 1'b1);
        e.da   = ref_model(in_data, 1'b0);
        sbq.push_back(e);
      end
    end
  end

  initial forever begin
    bit ev;
    @(negedge clk);
    if (mon_en) begin
      while (sbq.size() > 0 && sbq[0].acc < ecnt - 2) void'(sbq.pop_front());
      ev = (sbq.size() > 0) && (sbq[0].acc == ecnt - 2);
      chk("sb_valid", 32'(m_valid), 32'(ev));
      chk("sb_valid_a", 32'(a_valid), 32'(ev));
      if (ev) begin
        chk("sb_data", 32'(m_data), 32'(sbq[0].dm));
        chk("sb_user", 32'(m_user), 32'(sbq[0].user));
        chk("sb_data_a", 32'(a_data), 32'(sbq[0].da));
        chk("sb_user_a", 32'(a_user), 32'(sbq[0].user[1:0]));
        if (m_valid) begin
          out_cnt++;
          if (m_user[8]) begin
            last_seen++;
            last_pos = out_cnt;
          end
        end
      end
    end
  end

  task automatic pulse(input vec_t v);
    @(negedge clk);
    in_data = v.img; in_user = v.user; in_valid = 1'b1; cke = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    chk({v.name, "_lat1_valid"}, 32'(m_valid), 0);
    @(negedge clk);
    chk({v.name, "_lat2_valid"}, 32'(m_valid), 0);
    @(negedge clk);
    chk({v.name, "_valid"}, 32'(m_valid), 1);
    chk({v.name, "_data"}, 32'(m_data), 32'(v.exp_maj));
    chk({v.name, "_user"}, 32'(m_user), 32'(v.user));
    chk({v.name, "_valid_a"}, 32'(a_valid), 1);
    chk({v.name, "_data_a"}, 32'(a_data), 32'(v.exp_bit0));
    chk({v.name, "_user_a"}, 32'(a_user), 32'(v.user[1:0]));
    @(negedge clk);
    chk({v.name, "_after_valid"}, 32'(m_valid), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, 32'(m_valid), 0);
    chk({nm, "_data"}, 32'(m_data), 0);
    chk({nm, "_user"}, 32'(m_user), 0);
    chk({nm, "_valid_a"}, 32'(a_valid), 0);
    chk({nm, "_data_a"}, 32'(a_data), 0);
  endtask

  initial begin
    vec_t vecs[4];
    vec_t post_rst;
    logic [783:0] ones_img;
    ones_img = {784{1'b1}};
    vecs[0] = '{784'd0,  9'h001, 10'h000, 10'h000, "zeros"};
    vecs[1] = '{ones_img, 9'h002, 10'h3FF, 10'h3FF, "ones"};
    vecs[2] = '{784'd1,  9'h003, 10'h000, 10'h001, "pixel0"};
    vecs[3] = '{ones_img, 9'h0FF, 10'h3FF, 10'h3FF, "ones_user"};
    post_rst = '{ones_img, 9'h055, 10'h3FF, 10'h3FF, "post_reset"};

    reset = 1'b1; cke = 1'b1; in_valid = 1'b0; in_data = '0; in_user = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    reset = 1'b0;
    mon_en = 1'b1;

    foreach (vecs[i]) pulse(vecs[i]);

    // cke gap before and after the sample reaches the output, then reset while frozen
    @(negedge clk);
    in_data = ones_img; in_user = 9'h0AA; in_valid = 1'b1; cke = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    cke = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("freeze_pre_valid", 32'(m_valid), 0);
    end
    cke = 1'b1;
    @(negedge clk);
    chk("freeze_out_valid", 32'(m_valid), 1);
    cke = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("freeze_hold_valid", 32'(m_valid), 1);
      chk("freeze_hold_data", 32'(m_data), 32'h3FF);
      chk("freeze_hold_user", 32'(m_user), 32'h0AA);
    end
    reset = 1'b1;
    @(negedge clk);
    chk_zero("reset_over_cke");
    reset = 1'b0; cke = 1'b1;

    // reset with samples in flight
    @(negedge clk);
    in_valid = 1'b1; in_data = rand_img(); in_user = 9'h011;
    @(negedge clk);
    in_data = rand_img(); in_user = 9'h012;
    @(negedge clk);
    reset = 1'b1; in_user = 9'h013;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    chk_zero("flush_reset");
    repeat (4) begin
      @(negedge clk);
      chk("flush_no_valid", 32'(m_valid), 0);
    end
    pulse(post_rst);

    // 10000 back-to-back images, last flag on the final one
    out_cnt = 0; last_seen = 0; last_pos = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      in_valid = 1'b1; cke = 1'b1;
      in_data = rand_img();
      in_user = {(i == 9999), i[7:0]};
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("stream_out_count", 32'(out_cnt), 10000);
    chk("stream_last_count", 32'(last_seen), 1);
    chk("stream_last_pos", 32'(last_pos), 10000);

    // pseudo-random cke and valid gaps
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cke = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = rand_img();
      in_user = {1'b0, 8'($urandom_range(0, 255))};
    end
    @(negedge clk);
    cke = 1'b1; in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("drain_valid", 32'(m_valid), 0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mnist_lut_simple_classifier.md
# mnist_lut_simple_classifier

Fully pipelined binary LUT-network classifier for 28×28 binarized MNIST images. It accepts one 784-bit image per clock and emits 10 class-vote bits three cycles later. A user sideband (label, last flag, etc.) travels alongside unchanged. It sits between the image source and a downstream argmax/accuracy stage; there is no backpressure.

## Interface
Parameters:
- USER_WIDTH, 2: width of the pass-through sideband.
- INIT0, default = majority table replicated: 256×64-bit truth tables for layer 0. LUT k occupies bits [k*64 +: 64].
- INIT1, default = majority table replicated: 64×64-bit truth tables for layer 1.
- INIT2, default = majority table replicated: 10×64-bit truth tables for layer 2.
- Majority table: output 1 iff at least 3 of the 6 address bits are 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cke  in  1  clock enable; when 0, every register holds.
- in_user  in  USER_WIDTH  sideband, sampled with in_data.
- in_data  in  784  image bits; pixel p = row*28+col at bit p.
- in_valid  in  1  in_data/in_user are valid this cycle.
- out_user  out  USER_WIDTH  sideband delayed 3 stages.
- out_data  out  10  class bits; bit c = vote for digit c.
- out_valid  out  1  outputs are valid.

## Operation
- Three layers, each built from 6-input LUTs, with every layer output registered.
- Layer 0 has 256 LUTs and reads in_data (N_prev = 784).
- Layer 1 has 64 LUTs and reads the layer 0 outputs (N_prev = 256).
- Layer 2 has 10 LUTs and reads the layer 1 outputs (N_prev = 64).
- Connectivity is fixed: input m (0..5) of LUT k connects to previous-layer bit (k*6+m) mod N_prev.
- Input m drives address bit m. LUT output = INITx[k*64 + addr].
- out_data equals the layer 2 registers.
- in_valid and in_user shift through a 3-stage register chain in lockstep with the data.
- Data registers load on every cke=1 edge regardless of valid.
  - out_data is meaningful only while out_valid=1.
  - X inputs on invalid cycles must not corrupt the valid chain.
- No accumulation or argmax inside the block.
  - Tie-breaking, argmax and multi-channel summation are the consumer's job.
  - Downstream counts ones per class and picks the lowest index among the maxima.

## Timing
- Latency is exactly 3 cke-enabled edges.
  - A sample accepted at edge t (cke=1, in_valid=1) appears on out_* after edge t+2, i.e. visible from cycle t+3 onward.
- Throughput is one image per clock. Back-to-back valids are supported, with no bubbles and no stalls.
- cke=0 freezes all data, user and valid stages. No sample is lost or duplicated across a cke gap.
- Reset, synchronous and active-high, clears all valid stages, user stages and data registers to 0.
  - out_valid=0, out_user=0, out_data=0 on the cycle after the reset edge.
- Reset wins over cke.
- Reset mid-stream discards all in-flight samples. The first post-reset input appears 3 edges after acceptance.
- Ordering is strictly preserved. The sideband bit used as a "last" flag exits with its own image.

## Test plan
- All-zero image, default INITs, in_user=2'b01, single valid pulse -> exactly 3 cycles later: out_valid=1 for one cycle, out_data=10'h000, out_user=2'b01.
- All-ones image, default INITs -> out_data=10'h3FF with latency 3; previous/next cycles out_valid=0.
- Custom INITs: every LUT = address bit 0 (table 64'hAAAA_AAAA_AAAA_AAAA); image with only pixel 0 set.
  - Layer 0 LUT 0 =1; layer 1 LUT 0 =1; layer 2 LUT 0 =1.
  - Response: out_data=10'h001.
- Stream of 10000 back-to-back images, USER_WIDTH=9 (last flag + 8-bit label), cke=1.
  - out_valid continuous for 10000 cycles; labels exit in order.
  - Last flag asserts only on the 10000th output.
  - Matches a bit-accurate software model of the connectivity/INIT rules on every sample.
- cke toggled 0/1 pseudo-randomly during a stream -> output sequence identical to the cke=1 run, with no drops or duplicates.
- Reset asserted for 1 cycle while 3 samples are in flight -> those samples never appear. out_valid=0 until 3 edges after the next accepted input.
